// File: rtl/guess_game_core.sv
// Code-guessing game core: a secret code is keyed in, then guesses are scored
// per position against it until a win or until the allowed turns run out.
module guess_game_core #(
  parameter int NSYM    = 4,
  parameter int MAXLEN  = 7,
  parameter int MINLEN  = 4,
  parameter int MAXTURN = 4,
  localparam int SW = (NSYM > 1) ? $clog2(NSYM) : 1,
  localparam int LW = $clog2(MAXLEN + 1),
  localparam int TW = $clog2(MAXTURN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSYM-1:0]   key,
  input  logic              enter,
  output logic [LW-1:0]     numa,
  output logic [LW-1:0]     numb,
  output logic [2:0]        phase,
  output logic [MAXLEN-1:0] suc,
  output logic [LW-1:0]     hits,
  output logic [TW-1:0]     turns_left,
  output logic              win,
  output logic              lose,
  output logic              equal,
  output logic              bigger,
  output logic              smaller
);

  typedef enum logic [2:0] {
    ST_SET   = 3'd0,
    ST_GUESS = 3'd1,
    ST_CHECK = 3'd2,
    ST_WON   = 3'd3,
    ST_LOST  = 3'd4
  } phase_t;

  localparam logic [LW-1:0] MAXL = LW'(MAXLEN);
  localparam logic [LW-1:0] MINL = LW'(MINLEN);

  function automatic logic is_single(input logic [NSYM-1:0] v);
    return (v != '0) && ((v & (v - NSYM'(1))) == '0);
  endfunction

  function automatic logic [SW-1:0] onehot_idx(input logic [NSYM-1:0] v);
    logic [SW-1:0] idx;
    idx = '0;
    for (int k = 0; k < NSYM; k++)
      if (v[k]) idx = SW'(k);
    return idx;
  endfunction

  function automatic logic [LW-1:0] popcount(input logic [MAXLEN-1:0] v);
    logic [LW-1:0] n;
    n = '0;
    for (int i = 0; i < MAXLEN; i++)
      n = n + LW'(v[i]);
    return n;
  endfunction

  phase_t            state, state_nx;
  logic [NSYM-1:0]   key_q;
  logic              enter_q;
  logic [SW-1:0]     secret [MAXLEN];
  logic [SW-1:0]     guess  [MAXLEN];

  logic [NSYM-1:0]   press;
  logic              enter_p, single;
  logic [SW-1:0]     sym;
  logic              store_a, store_b, do_check;
  logic [MAXLEN-1:0] suc_nx;
  logic [LW-1:0]     hits_nx;
  logic              is_win, last_turn;

  assign press     = key & ~key_q;
  assign enter_p   = enter & ~enter_q;
  assign single    = is_single(press);
  assign sym       = onehot_idx(press);
  assign phase     = state;
  assign last_turn = (turns_left == TW'(1));

  always_comb begin
    for (int i = 0; i < MAXLEN; i++)
      suc_nx[i] = (LW'(i) < numa) && (LW'(i) < numb) && (secret[i] == guess[i]);
  end

  assign hits_nx = popcount(suc_nx);
  assign is_win  = (numa == numb) && (hits_nx == numa);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_SET;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    store_a  = 1'b0;
    store_b  = 1'b0;
    do_check = 1'b0;
    case (state)
      ST_SET: begin
        // A full secret advances without waiting for enter.
        if (numa == MAXL)                     state_nx = ST_GUESS;
        else if (enter_p && numa >= MINL)     state_nx = ST_GUESS;
        else if (single)                      store_a  = 1'b1;
      end
      ST_GUESS: begin
        if (enter_p && numb >= MINL)          state_nx = ST_CHECK;
        else if (single && numb < MAXL)       store_b  = 1'b1;
      end
      ST_CHECK: begin
        do_check = 1'b1;
        if (is_win)         state_nx = ST_WON;
        else if (last_turn) state_nx = ST_LOST;
        else                state_nx = ST_GUESS;
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q      <= '0;
      enter_q    <= 1'b0;
      numa       <= '0;
      numb       <= '0;
      suc        <= '0;
      hits       <= '0;
      turns_left <= TW'(MAXTURN);
      win        <= 1'b0;
      lose       <= 1'b0;
      equal      <= 1'b0;
      bigger     <= 1'b0;
      smaller    <= 1'b0;
      for (int i = 0; i < MAXLEN; i++) begin
        secret[i] <= '0;
        guess[i]  <= '0;
      end
    end else begin
      key_q   <= key;
      enter_q <= enter;
      if (store_a) begin
        for (int i = 0; i < MAXLEN; i++)
          if (LW'(i) == numa) secret[i] <= sym;
        numa <= numa + LW'(1);
      end
      if (store_b) begin
        for (int i = 0; i < MAXLEN; i++)
          if (LW'(i) == numb) guess[i] <= sym;
        numb <= numb + LW'(1);
      end
      // Scoring: results are registered as CHECK closes.
      if (do_check) begin
        suc  <= suc_nx;
        hits <= hits_nx;
        if (is_win) begin
          win     <= 1'b1;
          equal   <= 1'b1;
          bigger  <= 1'b0;
          smaller <= 1'b0;
        end else begin
          turns_left <= turns_left - TW'(1);
          smaller    <= (numb > numa);
          bigger     <= (numb < numa);
          equal      <= (numb == numa);
          lose       <= last_turn;
          numb       <= '0;
          for (int i = 0; i < MAXLEN; i++)
            guess[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_guess_game_core.sv
// Bench for guess_game_core: directed scenarios plus random play, checked
// against an action-level game model built on queues.
module tb_guess_game_core;
  localparam int NSYM = 4, MAXLEN = 7, MINLEN = 4, MAXTURN = 4;
  localparam int LW = 3, TW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NSYM-1:0] key = '0;
  logic            enter = 1'b0;
  logic [LW-1:0]   numa, numb, hits;
  logic [2:0]      phase;
  logic [MAXLEN-1:0] suc;
  logic [TW-1:0]   turns_left;
  logic            win, lose, equal, bigger, smaller;

  guess_game_core #(.NSYM(NSYM), .MAXLEN(MAXLEN), .MINLEN(MINLEN), .MAXTURN(MAXTURN)) dut (
    .clk(clk), .reset(reset), .key(key), .enter(enter),
    .numa(numa), .numb(numb), .phase(phase), .suc(suc), .hits(hits),
    .turns_left(turns_left), .win(win), .lose(lose),
    .equal(equal), .bigger(bigger), .smaller(smaller)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Game model: phase 0 SET, 1 GUESS, 3 WON, 4 LOST (CHECK is transient).
  int m_sec[$], m_gs[$];
  int m_phase, m_turns, m_win, m_lose, m_eq, m_bg, m_sm, m_suc, m_hits;

  function automatic void m_reset();
    m_sec.delete(); m_gs.delete();
    m_phase = 0; m_turns = MAXTURN;
    m_win = 0; m_lose = 0; m_eq = 0; m_bg = 0; m_sm = 0; m_suc = 0; m_hits = 0;
  endfunction

  function automatic void m_key(input int k);
    if (m_phase == 0 && m_sec.size() < MAXLEN) begin
      m_sec.push_back(k);
      if (m_sec.size() == MAXLEN) m_phase = 1;
    end else if (m_phase == 1 && m_gs.size() < MAXLEN) begin
      m_gs.push_back(k);
    end
  endfunction

  function automatic void m_enter();
    int la, lb, mn;
    if (m_phase == 0 && m_sec.size() >= MINLEN) begin
      m_phase = 1;
    end else if (m_phase == 1 && m_gs.size() >= MINLEN) begin
      la = m_sec.size(); lb = m_gs.size();
      mn = (la < lb) ? la : lb;
      m_suc = 0; m_hits = 0;
      for (int i = 0; i < mn; i++)
        if (m_sec[i] == m_gs[i]) begin
          m_suc |= (1 << i);
          m_hits++;
        end
      if (la == lb && m_hits == la) begin
        m_phase = 3; m_win = 1; m_eq = 1; m_bg = 0; m_sm = 0;
      end else begin
        m_turns--;
        m_sm = (lb > la); m_bg = (lb < la); m_eq = (lb == la);
        m_gs.delete();
        if (m_turns == 0) begin
          m_lose = 1; m_phase = 4;
        end else begin
          m_phase = 1;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [NSYM-1:0] k, input logic e);
    key = k; enter = e;
    tick();
  endtask

  task automatic act_key(input int k, input int hold);
    logic [NSYM-1:0] v;
    v = '0; v[k] = 1'b1;
    for (int h = 0; h < hold; h++) cyc(v, 1'b0);
    cyc('0, 1'b0);
    m_key(k);
  endtask

  task automatic act_enter();
    cyc('0, 1'b1);
    cyc('0, 1'b0);
    m_enter();
  endtask

  task automatic act_double();
    logic [NSYM-1:0] v;
    int a, b;
    a = $urandom_range(0, NSYM - 1);
    b = (a + $urandom_range(1, NSYM - 1)) % NSYM;
    v = '0; v[a] = 1'b1; v[b] = 1'b1;
    cyc(v, 1'b0);
    cyc('0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; key = '0; enter = 1'b0;
    tick();
    reset = 1'b0;
    m_reset();
  endtask

  task automatic check_all(input string tag);
    check({tag, ".phase"}, phase, m_phase);
    check({tag, ".numa"}, numa, m_sec.size());
    check({tag, ".numb"}, numb, m_gs.size());
    check({tag, ".suc"}, suc, m_suc);
    check({tag, ".hits"}, hits, m_hits);
    check({tag, ".turns"}, turns_left, m_turns);
    check({tag, ".win"}, win, m_win);
    check({tag, ".lose"}, lose, m_lose);
    check({tag, ".equal"}, equal, m_eq);
    check({tag, ".bigger"}, bigger, m_bg);
    check({tag, ".smaller"}, smaller, m_sm);
  endtask

  task automatic enter_secret_01230();
    int s[5] = '{0, 1, 2, 3, 0};
    foreach (s[i]) act_key(s[i], 1);
    act_enter();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".phase"}, phase, 0);
    check({tag, ".numa"}, numa, 0);
    check({tag, ".numb"}, numb, 0);
    check({tag, ".suc"}, suc, 0);
    check({tag, ".hits"}, hits, 0);
    check({tag, ".turns"}, turns_left, MAXTURN);
    check({tag, ".flags"}, {win, lose, equal, bigger, smaller}, 0);
  endtask

  initial begin
    m_reset();
    tick(); tick();
    reset = 1'b0;
    check_reset_values("rst");

    // Win on exact match, with CHECK latency observed.
    enter_secret_01230();
    check("win.set_done", phase, 1);
    begin
      int g[5] = '{0, 1, 2, 3, 0};
      foreach (g[i]) act_key(g[i], 1);
    end
    cyc('0, 1'b1);
    check("win.in_check", phase, 2);
    check("win.not_yet", win, 0);
    cyc('0, 1'b0);
    m_enter();
    check("win.win", win, 1);
    check("win.equal", equal, 1);
    check("win.suc", suc, 7'b0011111);
    check("win.hits", hits, 5);
    check("win.phase", phase, 3);
    check_all("win");
    act_key(1, 1);
    act_enter();
    check_all("won_hold");

    // Short guess, then run out of turns.
    do_reset();
    enter_secret_01230();
    for (int i = 0; i < 4; i++) act_key(i, 1);
    act_enter();
    check("short.smaller", smaller, 0);
    check("short.bigger", bigger, 1);
    check("short.hits", hits, 4);
    check("short.turns", turns_left, 3);
    check("short.numb", numb, 0);
    check("short.phase", phase, 1);
    check_all("short");
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 5; i++) act_key(1, 1);
      act_enter();
      check_all("miss");
    end
    check("lost.lose", lose, 1);
    check("lost.turns", turns_left, 0);
    check("lost.phase", phase, 4);
    act_key(2, 1);
    check("lost.numb", numb, 0);
    check_all("lost_hold");

    // SET entry rules and full-length guess.
    do_reset();
    for (int i = 0; i < 3; i++) act_key(i, 1);
    act_enter();
    check("set3.phase", phase, 0);
    check("set3.numa", numa, 3);
    act_double();
    check("dbl.numa", numa, 3);
    for (int i = 0; i < 4; i++) act_key(i, 1);
    check("set7.numa", numa, 7);
    check("set7.phase", phase, 1);
    for (int i = 0; i < 8; i++) act_key(i % NSYM, 1);
    check("g8.numb", numb, 7);
    check("g8.phase", phase, 1);
    check_all("set");

    // Reset mid-guess, held key, reset during CHECK.
    do_reset();
    for (int i = 0; i < 4; i++) act_key(i, 1);
    act_enter();
    act_key(1, 1); act_key(2, 1);
    check("mid.numb", numb, 2);
    do_reset();
    check_reset_values("rst_mid");
    act_key(3, 5);
    check("hold.numa", numa, 1);
    for (int i = 0; i < 3; i++) act_key(i, 1);
    act_enter();
    for (int i = 0; i < 4; i++) act_key(3 - i, 1);
    cyc('0, 1'b1);
    check("rchk.in_check", phase, 2);
    do_reset();
    check_reset_values("rst_chk");

    // Random play.
    for (int g = 0; g < 12; g++) begin
      do_reset();
      for (int a = 0; a < 50; a++) begin
        int r;
        r = $urandom_range(0, 99);
        if (m_phase == 1 && m_gs.size() == 0 && r < 15) begin
          int s[$];
          s = m_sec;
          foreach (s[i]) act_key(s[i], 1);
          act_enter();
        end else if (r < 60) act_key($urandom_range(0, NSYM - 1), 1);
        else if (r < 75) act_enter();
        else if (r < 85) act_double();
        else act_key($urandom_range(0, NSYM - 1), $urandom_range(2, 5));
        check_all("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/guess_game_core.md
GUESS_GAME_CORE -- requirements
Module: guess_game_core

Interface
REQ-001 SHALL expose parameter NSYM, default 4: number of symbol keys; code symbols are 0..NSYM-1.
REQ-002 SHALL expose parameter MAXLEN, default 7: maximum code/guess length in symbols.
REQ-003 SHALL expose parameter MINLEN, default 4: minimum length before enter is accepted; 1 <= MINLEN <= MAXLEN.
REQ-004 SHALL expose parameter MAXTURN, default 4: number of non-winning guesses allowed before loss.
REQ-005 SHALL derive SW = clog2(NSYM) (min 1), LW = clog2(MAXLEN+1), TW = clog2(MAXTURN+1).
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 Ports (name, direction, width, meaning):
  clk  input  1  rising-edge clock
  reset  input  1  synchronous active-high reset
  key  input  NSYM  level button inputs; bit k = symbol k
  enter  input  1  level enter button
  numa  output  LW  secret length entered
  numb  output  LW  current guess length
  phase  output  3  state: 0 SET, 1 GUESS, 2 CHECK, 3 WON, 4 LOST
  suc  output  MAXLEN  per-position match mask of last check
  hits  output  LW  popcount of suc
  turns_left  output  TW  MAXTURN minus failed guesses
  win, lose  output  1  game result flags
  equal, bigger, smaller  output  1  length feedback of last check

Function
REQ-008 SHALL detect presses as rising edges: press = key & ~key_q, enter_p = enter & ~enter_q, key_q/enter_q registered each cycle.
REQ-009 A cycle with more than one bit of press set SHALL be ignored entirely (no symbol stored, length unchanged).
REQ-010 SET: a single-key press with numa < MAXLEN SHALL store index k at secret position numa and increment numa at that edge.
REQ-011 SET: enter_p with numa >= MINLEN, or numa reaching MAXLEN, SHALL move to GUESS on the next edge; enter_p with numa < MINLEN SHALL be ignored.
REQ-012 GUESS: a single-key press with numb < MAXLEN SHALL store k at guess position numb and increment numb; presses at numb == MAXLEN ignored (no auto-submit).
REQ-013 GUESS: enter_p with numb >= MINLEN SHALL move to CHECK; otherwise ignored.
REQ-014 CHECK SHALL last exactly one cycle; keys and enter ignored; results registered at its closing edge (flags valid 2 edges after enter_p edge).
REQ-015 suc[i] SHALL be 1 iff i < min(numa,numb) and secret[i] == guess[i]; hits = popcount(suc).
REQ-016 Win condition: numa == numb and hits == numa.
REQ-017 On win: win=1, equal=1, bigger=0, smaller=0, phase -> WON.
REQ-018 On non-win: turns_left decrements; smaller=1 if numb>numa, bigger=1 if numb<numa, equal=1 if numb==numa (exactly one set).
REQ-019 On non-win with turns_left reaching 0: lose=1, phase -> LOST; else phase -> GUESS with numb=0 and guess storage cleared.
REQ-020 WON and LOST SHALL hold all outputs until reset; all key/enter activity ignored.
REQ-021 Feedback flags, suc and hits SHALL hold their values until the next CHECK or reset.
REQ-022 Key held across cycles SHALL register exactly one symbol.

Reset
REQ-023 reset=1 at a clock edge SHALL override all other activity, including mid-entry and CHECK.
REQ-024 After reset: phase=SET, numa=0, numb=0, secret/guess storage 0, suc=0, hits=0, turns_left=MAXTURN, win=lose=equal=bigger=smaller=0, key_q/enter_q=0.

Verification
REQ-025 Defaults: secret 0,1,2,3,0 + enter; guess 0,1,2,3,0 + enter -> 2 edges later win=1, equal=1, suc=7'b0011111 (bits 0-4), hits=5, phase=WON.
REQ-026 Secret 0,1,2,3,0; guess 0,1,2,3 + enter -> smaller=0, bigger=1, hits=4, turns_left=3, numb=0, phase=GUESS.
REQ-027 Four non-winning guesses -> after fourth CHECK lose=1, turns_left=0, phase=LOST; further keys leave numb=0.
REQ-028 SET: enter after 3 symbols -> ignored, phase=SET; 7 symbols -> auto GUESS, numa=7; key 0 and 1 rising same cycle -> numa unchanged.
REQ-029 Reset asserted during GUESS with numb=2 -> next edge all outputs at REQ-024 values; key held high 5 cycles -> one symbol stored.
